conv3_window_feeder: RTL and testbench

Streaming front end for the 3x3 FP16 convolution core. It loads the 3x3 kernel from a weight stream, then accepts a raster-order pixel stream. Two line buffers build the vertical 3-pixel columns that the core shifts into its window. It also generates the core's `valid_in`, `kernel_load` and `valid_out` strobes, and tags each finished result with its output coordinates for the downstream pooling/activation stage.

---
 rtl/conv3_window_feeder_if.sv | 21 ++
 rtl/conv3_window_feeder.sv | 174 +++++++++++++++++
 tb/tb_conv3_window_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3_window_feeder_if.sv
// Weight and pixel stream handshakes into the 3x3 window feeder.
interface conv3_window_feeder_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  w_valid;
   logic                  w_ready;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  pix_valid;
   logic                  pix_ready;
   logic [DATA_WIDTH-1:0] pix_data;

   modport master (
      output w_valid, w_data, pix_valid, pix_data,
      input  w_ready, pix_ready
   );

   modport slave (
      input  w_valid, w_data, pix_valid, pix_data,
      output w_ready, pix_ready
   );
endinterface

// File: rtl/conv3_window_feeder.sv
// Kernel loader, line-buffered column builder and result tagger in front of
// the 3x3 FP16 convolution core.
module conv3_window_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   conv3_window_feeder_if.slave          strm,
   output logic [DATA_WIDTH-1:0]         conv_data0,
   output logic [DATA_WIDTH-1:0]         conv_data1,
   output logic [DATA_WIDTH-1:0]         conv_data2,
   output logic                          conv_valid_in,
   output logic                          conv_kernel_load,
   output logic                          conv_valid_out,
   output logic                          res_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0] res_row,
   output logic [$clog2(IMG_WIDTH)-1:0]  res_col,
   output logic                          busy,
   output logic                          frame_done
);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int CW = $clog2(IMG_WIDTH);

   typedef enum logic [1:0] {IDLE, KLOAD, STREAM, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [1:0]            wcnt, wcol, dcnt;
   logic [RW-1:0]         row;
   logic [CW-1:0]         col;
   logic                  w_acc, pix_acc, last_w, last_pix, win_done;
   logic [DATA_WIDTH-1:0] w_hold0, w_hold1;
   logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

   logic                  vld_p0, vld_p1, vld_p2;
   logic [RW-1:0]         row_p0, row_p1, row_p2;
   logic [CW-1:0]         col_p0, col_p1, col_p2;

   assign strm.w_ready   = (state == KLOAD);
   assign strm.pix_ready = (state == STREAM);
   assign busy           = (state != IDLE);

   assign w_acc    = strm.w_valid && (state == KLOAD);
   assign pix_acc  = strm.pix_valid && (state == STREAM);
   assign last_w   = (wcol == 2'd2) && (wcnt == 2'd2);
   assign last_pix = (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
   assign win_done = pix_acc && (row >= RW'(2)) && (col >= CW'(2));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = KLOAD;
         KLOAD:   if (w_acc && last_w) state_nxt = STREAM;
         STREAM:  if (pix_acc && last_pix) state_nxt = DRAIN;
         DRAIN:   if (dcnt == 2'd3) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         wcnt <= '0;
         wcol <= '0;
         dcnt <= '0;
         row  <= '0;
         col  <= '0;
      end else begin
         if (w_acc) begin
            if (wcnt == 2'd2) begin
               wcnt <= '0;
               wcol <= wcol + 2'd1;
            end else begin
               wcnt <= wcnt + 2'd1;
            end
         end
         if (pix_acc) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
               col <= '0;
               row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      end
   end

   // First two weights of a column wait here until the third completes the group.
   always_ff @(posedge clk) begin
      if (w_acc && wcnt == 2'd0) w_hold0 <= strm.w_data;
      if (w_acc && wcnt == 2'd1) w_hold1 <= strm.w_data;
   end

   always_ff @(posedge clk) begin
      if (pix_acc) begin
         lb1[col] <= lb0[col];
         lb0[col] <= strm.pix_data;
      end
   end

   // Core shift strobes: one kernel column per weight group, one pixel column per pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         conv_data0       <= '0;
         conv_data1       <= '0;
         conv_data2       <= '0;
         conv_valid_in    <= 1'b0;
         conv_kernel_load <= 1'b0;
      end else begin
         conv_valid_in    <= 1'b0;
         conv_kernel_load <= 1'b0;
         if (w_acc && wcnt == 2'd2) begin
            conv_data2       <= w_hold0;
            conv_data1       <= w_hold1;
            conv_data0       <= strm.w_data;
            conv_valid_in    <= 1'b1;
            conv_kernel_load <= 1'b1;
         end else if (pix_acc) begin
            conv_data2    <= lb1[col];
            conv_data1    <= lb0[col];
            conv_data0    <= strm.pix_data;
            conv_valid_in <= (row >= RW'(2));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         row_p0     <= '0;
         row_p1     <= '0;
         row_p2     <= '0;
         col_p0     <= '0;
         col_p1     <= '0;
         col_p2     <= '0;
         res_valid  <= 1'b0;
         res_row    <= '0;
         res_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         // p0: window completed by the pixel accepted last cycle
         vld_p0 <= win_done;
         row_p0 <= win_done ? row - RW'(2) : '0;
         col_p0 <= win_done ? col - CW'(2) : '0;
         // p1: core shifting the column in
         vld_p1 <= vld_p0;
         row_p1 <= row_p0;
         col_p1 <= col_p0;
         // p2: core result register loading, drives conv_valid_out
         vld_p2 <= vld_p1;
         row_p2 <= row_p1;
         col_p2 <= col_p1;
         // result stage: core data_out valid
         res_valid  <= vld_p2;
         res_row    <= row_p2;
         res_col    <= col_p2;
         frame_done <= vld_p2 && (row_p2 == RW'(IMG_HEIGHT - 3)) &&
                       (col_p2 == CW'(IMG_WIDTH - 3));
      end
   end

   assign conv_valid_out = vld_p2;

endmodule

// File: tb/tb_conv3_window_feeder.sv
// Scoreboard bench for conv3_window_feeder on a 5x5 frame: expected core
// shifts and tagged results are queued by the driver and popped by a monitor.
module tb_conv3_window_feeder;
   localparam int DW = 16;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);

   typedef struct packed {
      logic          kl;
      logic [DW-1:0] d2;
      logic [DW-1:0] d1;
      logic [DW-1:0] d0;
   } shift_t;

   typedef struct packed {
      logic [RW-1:0] row;
      logic [CW-1:0] col;
      logic          last;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [DW-1:0] conv_data0, conv_data1, conv_data2;
   logic conv_valid_in, conv_kernel_load, conv_valid_out;
   logic res_valid, busy, frame_done;
   logic [RW-1:0] res_row;
   logic [CW-1:0] res_col;

   int errors = 0;
   int checks = 0;
   int res_seen = 0;
   logic prev_cvo = 1'b0;
   shift_t shift_q[$];
   res_t   res_q[$];

   logic [DW-1:0] wts [9] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                              16'h4600, 16'h4700, 16'h4800, 16'h4880};

   always #5 clk = ~clk;

   conv3_window_feeder_if #(.DATA_WIDTH(DW)) strm();

   conv3_window_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .start(start), .strm(strm),
      .conv_data0(conv_data0), .conv_data1(conv_data1), .conv_data2(conv_data2),
      .conv_valid_in(conv_valid_in), .conv_kernel_load(conv_kernel_load),
      .conv_valid_out(conv_valid_out), .res_valid(res_valid),
      .res_row(res_row), .res_col(res_col), .busy(busy), .frame_done(frame_done)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return 16'h4000 | 16'(r * 16 + c);
   endfunction

   always @(negedge clk) begin
      shift_t es;
      res_t   er;
      if (conv_valid_in === 1'b1) begin
         if (shift_q.size() == 0) begin
            chk("unexpected_shift", 64'(conv_valid_in), 64'd0);
         end else begin
            es = shift_q.pop_front();
            chk("shift_kernel_load", 64'(conv_kernel_load), 64'(es.kl));
            chk("shift_data", 64'({conv_data2, conv_data1, conv_data0}),
                64'({es.d2, es.d1, es.d0}));
         end
      end
      if (res_valid === 1'b1) begin
         res_seen++;
         chk("valid_out_lead", 64'(prev_cvo), 64'd1);
         if (res_q.size() == 0) begin
            chk("unexpected_result", 64'(res_valid), 64'd0);
         end else begin
            er = res_q.pop_front();
            chk("res_coord", 64'({res_row, res_col}), 64'({er.row, er.col}));
            chk("frame_done", 64'(frame_done), 64'(er.last));
         end
      end else if (frame_done === 1'b1) begin
         chk("frame_done_alone", 64'(frame_done), 64'd0);
      end
      prev_cvo = conv_valid_out;
   end

   task automatic check_zero(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_w_ready"}, 64'(strm.w_ready), 64'd0);
      chk({nm, "_pix_ready"}, 64'(strm.pix_ready), 64'd0);
      chk({nm, "_data"}, 64'({conv_data2, conv_data1, conv_data0}), 64'd0);
      chk({nm, "_strobes"}, 64'({conv_valid_in, conv_kernel_load, conv_valid_out}), 64'd0);
      chk({nm, "_res"}, 64'({res_valid, res_row, res_col, frame_done}), 64'd0);
   endtask

   task automatic do_start();
      res_seen = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("w_ready_after_start", 64'(strm.w_ready), 64'd1);
   endtask

   task automatic load_weights(input bit stall, input bit ign);
      for (int k = 0; k < 9; k++) begin
         if (stall) begin
            repeat ($urandom_range(0, 2)) begin
               strm.w_valid = 1'b0;
               chk("w_ready_stall", 64'(strm.w_ready), 64'd1);
               @(posedge clk); #1;
            end
         end
         if (ign && k == 4) begin
            strm.w_valid   = 1'b0;
            strm.pix_valid = 1'b1;
            strm.pix_data  = 16'hDEAD;
            chk("pix_ready_in_kload", 64'(strm.pix_ready), 64'd0);
            @(posedge clk); #1;
            strm.pix_valid = 1'b0;
         end
         strm.w_valid = 1'b1;
         strm.w_data  = wts[k];
         chk("w_ready", 64'(strm.w_ready), 64'd1);
         if (k % 3 == 2) shift_q.push_back('{1'b1, wts[k-2], wts[k-1], wts[k]});
         @(posedge clk); #1;
      end
      strm.w_valid = 1'b0;
      chk("pix_ready_after_w9", 64'(strm.pix_ready), 64'd1);
      chk("w_ready_after_w9", 64'(strm.w_ready), 64'd0);
   endtask

   task automatic run_pixels(input bit stall, input bit ign, input int stop_r, input int stop_c);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == stop_r && c == stop_c) return;
            if (stall) begin
               repeat ($urandom_range(0, 2)) begin
                  strm.pix_valid = 1'b0;
                  @(posedge clk); #1;
               end
            end
            if (ign && r == 1 && c == 2) begin
               strm.pix_valid = 1'b0;
               start          = 1'b1;
               strm.w_valid   = 1'b1;
               strm.w_data    = 16'hBEEF;
               chk("w_ready_in_stream", 64'(strm.w_ready), 64'd0);
               @(posedge clk); #1;
               start        = 1'b0;
               strm.w_valid = 1'b0;
               chk("pix_ready_after_ignored", 64'(strm.pix_ready), 64'd1);
            end
            strm.pix_valid = 1'b1;
            strm.pix_data  = pix(r, c);
            chk("pix_ready", 64'(strm.pix_ready), 64'd1);
            if (r >= 2) shift_q.push_back('{1'b0, pix(r-2, c), pix(r-1, c), pix(r, c)});
            if (r >= 2 && c >= 2)
               res_q.push_back('{RW'(r-2), CW'(c-2), (r == H-1 && c == W-1)});
            @(posedge clk); #1;
         end
      end
      strm.pix_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("busy_drain", 64'(busy), 64'd1);
         chk("pix_ready_drain", 64'(strm.pix_ready), 64'd0);
         @(posedge clk); #1;
      end
      chk("busy_after_drain", 64'(busy), 64'd0);
      chk("results_per_frame", 64'(res_seen), 64'((W-2)*(H-2)));
      chk("res_queue_empty", 64'(res_q.size()), 64'd0);
      chk("shift_queue_empty", 64'(shift_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      strm.w_valid   = 1'b0;
      strm.w_data    = '0;
      strm.pix_valid = 1'b0;
      strm.pix_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Stream inputs while idle must do nothing.
      strm.w_valid   = 1'b1;
      strm.pix_valid = 1'b1;
      chk("w_ready_idle", 64'(strm.w_ready), 64'd0);
      chk("pix_ready_idle", 64'(strm.pix_ready), 64'd0);
      @(posedge clk); #1;
      strm.w_valid   = 1'b0;
      strm.pix_valid = 1'b0;
      chk("busy_idle", 64'(busy), 64'd0);

      do_start();
      load_weights(1'b0, 1'b1);
      run_pixels(1'b0, 1'b1, H, 0);

      do_start();
      load_weights(1'b1, 1'b0);
      run_pixels(1'b1, 1'b0, H, 0);

      // Abort at row 3, column 2 with results still in flight.
      do_start();
      load_weights(1'b0, 1'b0);
      run_pixels(1'b0, 1'b0, 3, 2);
      rst = 1'b1;
      strm.pix_valid = 1'b0;
      @(negedge clk); #1;
      shift_q.delete();
      res_q.delete();
      @(posedge clk); #1;
      check_zero("mid_reset");
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("busy_after_reset", 64'(busy), 64'd0);

      do_start();
      load_weights(1'b0, 1'b0);
      run_pixels(1'b0, 1'b0, H, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
